// File: rtl/snn_lif_layer_if.sv
// Handshake, weight-programming and control bundle for one LIF layer.
// The layer takes the slave view; the stage that drives the layer takes the master view.
interface snn_lif_layer_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 3,
  parameter int W_WIDTH     = 8
);
  localparam int WA = (NUM_NEURONS * NUM_INPUTS > 1) ? $clog2(NUM_NEURONS * NUM_INPUTS) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_INPUTS-1:0]     in_spikes;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_NEURONS-1:0]    out_spikes;
  logic                      w_we;
  logic [WA-1:0]             w_addr;
  logic signed [W_WIDTH-1:0] w_data;
  logic                      clear_state;

  modport master (
    output in_valid, in_spikes, out_ready, w_we, w_addr, w_data, clear_state,
    input  in_ready, out_valid, out_spikes
  );

  modport slave (
    input  in_valid, in_spikes, out_ready, w_we, w_addr, w_data, clear_state,
    output in_ready, out_valid, out_spikes
  );
endinterface

// File: rtl/snn_lif_layer.sv
// Fully-connected layer of leaky integrate-and-fire neurons, one neuron updated per cycle.
// Signed weights, arithmetic leak, saturating membrane and a refractory hold after each spike.
module snn_lif_layer #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 3,
  parameter int W_WIDTH     = 8,
  parameter int V_WIDTH     = 16,
  parameter int V_REST      = 0,
  parameter int V_RESET     = 0,
  parameter int V_TH        = 100,
  parameter int LEAK_SHIFT  = 3,
  parameter int REFRAC      = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  snn_lif_layer_if.slave  bus
);
  localparam int NW = NUM_NEURONS * NUM_INPUTS;
  localparam int WA = (NW > 1) ? $clog2(NW) : 1;
  localparam int JW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int AW = V_WIDTH + W_WIDTH + $clog2(NUM_INPUTS) + 1;

  localparam logic signed [AW-1:0]      V_REST_A  = AW'(V_REST);
  localparam logic signed [AW-1:0]      V_TH_A    = AW'(V_TH);
  localparam logic signed [AW-1:0]      V_MAX_A   = {{(AW-V_WIDTH+1){1'b0}}, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0]      V_MIN_A   = {{(AW-V_WIDTH+1){1'b1}}, {(V_WIDTH-1){1'b0}}};
  localparam logic signed [V_WIDTH-1:0] V_REST_V  = V_WIDTH'(V_REST);
  localparam logic signed [V_WIDTH-1:0] V_RESET_V = V_WIDTH'(V_RESET);
  localparam logic [RW-1:0]             REFRAC_V  = RW'(REFRAC);
  localparam logic [JW-1:0]             LAST_J    = JW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, DONE = 2'd2} state_t;

  state_t                    state_r, next_state_s;
  logic [JW-1:0]             cnt_r;
  logic [NUM_INPUTS-1:0]     spk_r;
  logic                      in_ready_r, out_valid_r, out_valid_s;
  logic [NUM_NEURONS-1:0]    out_spikes_r;
  logic                      accept_s, upd_s;
  logic signed [W_WIDTH-1:0] w_r      [NW];
  logic signed [V_WIDTH-1:0] v_r      [NUM_NEURONS];
  logic [RW-1:0]             refrac_r [NUM_NEURONS];

  logic signed [V_WIDTH-1:0] v_cur_s, v_next_s;
  logic signed [AW-1:0]      syn_s, leak_s, sum_s;
  logic                      fire_s;

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_spikes = out_spikes_r;

  // Membrane update datapath for the neuron selected by cnt_r, widened so nothing wraps before clamping.
  always_comb begin
    syn_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (spk_r[i]) begin
        syn_s = syn_s + AW'(w_r[WA'(32'(cnt_r) * NUM_INPUTS + i)]);
      end else begin
        syn_s = syn_s;
      end
    end
    v_cur_s = v_r[cnt_r];
    leak_s  = (AW'(v_cur_s) - V_REST_A) >>> LEAK_SHIFT;
    sum_s   = AW'(v_cur_s) - leak_s + syn_s;
    if (sum_s > V_MAX_A) begin
      v_next_s = V_MAX_A[V_WIDTH-1:0];
    end else if (sum_s < V_MIN_A) begin
      v_next_s = V_MIN_A[V_WIDTH-1:0];
    end else begin
      v_next_s = sum_s[V_WIDTH-1:0];
    end
    fire_s = (AW'(v_next_s) >= V_TH_A);
  end

  // Next-state and handshake decode; clear_state overrides everything.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    upd_s        = 1'b0;
    out_valid_s  = 1'b0;
    if (bus.clear_state) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            accept_s     = 1'b1;
            next_state_s = UPDATE;
          end else begin
            next_state_s = IDLE;
          end
        end
        UPDATE: begin
          upd_s = 1'b1;
          if (cnt_r == LAST_J) begin
            next_state_s = DONE;
          end else begin
            next_state_s = UPDATE;
          end
        end
        DONE: begin
          if (out_valid_r && bus.out_ready) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = DONE;
            out_valid_s  = 1'b1;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // FSM state, neuron index, latched input spikes and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      spk_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= out_valid_s;
      if (accept_s) begin
        cnt_r <= '0;
        spk_r <= bus.in_spikes;
      end else if (upd_s) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  // Weight memory; writes land only while idle, so a timestep always sees one consistent matrix.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NW; k++) begin
        w_r[k] <= '0;
      end
    end else if (state_r == IDLE && bus.w_we && (32'(bus.w_addr) < NW)) begin
      w_r[bus.w_addr] <= bus.w_data;
    end
  end

  // Per-neuron membrane, refractory counter and output spike bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_spikes_r <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_r[n]      <= V_REST_V;
        refrac_r[n] <= '0;
      end
    end else if (bus.clear_state) begin
      out_spikes_r <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_r[n]      <= V_REST_V;
        refrac_r[n] <= '0;
      end
    end else if (upd_s) begin
      if (refrac_r[cnt_r] != '0) begin
        refrac_r[cnt_r]     <= refrac_r[cnt_r] - 1'b1;
        v_r[cnt_r]          <= V_RESET_V;
        out_spikes_r[cnt_r] <= 1'b0;
      end else if (fire_s) begin
        refrac_r[cnt_r]     <= REFRAC_V;
        v_r[cnt_r]          <= V_RESET_V;
        out_spikes_r[cnt_r] <= 1'b1;
      end else begin
        v_r[cnt_r]          <= v_next_s;
        out_spikes_r[cnt_r] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_snn_lif_layer.sv
// Directed bench for snn_lif_layer: a default layer plus a V_WIDTH=10 copy fed identical stimulus.
// Expected membrane values and spikes are hand-computed from the LIF update rule.
module tb_snn_lif_layer;
  logic       clk;
  logic       reset_n;
  logic       in_valid, out_ready, w_we, clear_state;
  logic [3:0] in_spikes;
  logic [3:0] w_addr;
  logic [7:0] w_data;

  int n_vec = 0;
  int n_err = 0;

  snn_lif_layer_if #(.NUM_INPUTS(4), .NUM_NEURONS(3), .W_WIDTH(8)) bus ();
  snn_lif_layer_if #(.NUM_INPUTS(4), .NUM_NEURONS(3), .W_WIDTH(8)) bus_s ();

  assign bus.in_valid      = in_valid;
  assign bus.in_spikes     = in_spikes;
  assign bus.out_ready     = out_ready;
  assign bus.w_we          = w_we;
  assign bus.w_addr        = w_addr;
  assign bus.w_data        = w_data;
  assign bus.clear_state   = clear_state;
  assign bus_s.in_valid    = in_valid;
  assign bus_s.in_spikes   = in_spikes;
  assign bus_s.out_ready   = out_ready;
  assign bus_s.w_we        = w_we;
  assign bus_s.w_addr      = w_addr;
  assign bus_s.w_data      = w_data;
  assign bus_s.clear_state = clear_state;

  snn_lif_layer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  snn_lif_layer #(.V_WIDTH(10)) dut_s (.clk(clk), .reset_n(reset_n), .bus(bus_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    w_we   = 1'b1;
    w_addr = 4'(addr);
    w_data = 8'(data);
    tick();
    w_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_weight0", 32'(dut.w_r[0]), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  // One full timestep with out_ready high; optional weight write on the accept edge.
  task automatic timestep(input logic [3:0] spk, input bit do_w, input int addr, input int data,
                          output logic [2:0] res, output logic [2:0] res_s);
    int k;
    in_valid  = 1'b1;
    in_spikes = spk;
    if (do_w) begin
      w_we   = 1'b1;
      w_addr = 4'(addr);
      w_data = 8'(data);
    end
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("accept_ready", 32'(bus.in_ready), 1);
    tick();
    in_valid = 1'b0;
    w_we     = 1'b0;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("out_valid_wait", 32'(bus.out_valid), 1);
    res   = bus.out_spikes;
    res_s = bus_s.out_spikes;
    tick();
  endtask

  initial begin
    logic [2:0] r, rs;
    logic [3:0] spk_t [8] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
    int         exp_v [8] = '{80, 0, 0, 0, 80, 70, 62, 55};
    int         exp_r [8] = '{0, 1, 0, 0, 0, 0, 0, 0};

    reset_n = 1'b0; in_valid = 1'b0; in_spikes = 4'b0000; out_ready = 1'b1;
    w_we = 1'b0; w_addr = 4'd0; w_data = 8'd0; clear_state = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_spikes", 32'(bus.out_spikes), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 0);
    chk("reset_v0", 32'(dut.v_r[0]), 0);
    reset_n = 1'b1;
    tick();
    chk("in_ready_after_reset", 32'(bus.in_ready), 1);

    // Saturation: narrow copy clamps at -512, wide copy does not.
    for (int a = 0; a < 4; a++) wr(a, -128);
    timestep(4'b1111, 1'b0, 0, 0, r, rs);
    chk("sat1_v_narrow", 32'(dut_s.v_r[0]), -512);
    chk("sat1_v_wide", 32'(dut.v_r[0]), -512);
    chk("sat1_spk", 32'(rs), 0);
    timestep(4'b1111, 1'b0, 0, 0, r, rs);
    chk("sat2_v_narrow", 32'(dut_s.v_r[0]), -512);
    chk("sat2_v_wide", 32'(dut.v_r[0]), -960);
    chk("sat2_spk", 32'(rs), 0);
    do_reset();

    // Spike fan-out from input 3.
    wr(7, 127);
    wr(11, -5);
    timestep(4'b1000, 1'b0, 0, 0, r, rs);
    chk("fanout_spikes", 32'(r), 2);
    chk("fanout_v2", 32'(dut.v_r[2]), -5);
    chk("fanout_v1", 32'(dut.v_r[1]), 0);
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    chk("idle_clear_v2", 32'(dut.v_r[2]), 0);
    chk("idle_clear_refrac1", 32'(dut.refrac_r[1]), 0);
    chk("idle_clear_keeps_w", 32'(dut.w_r[7]), 127);

    // Integrate, fire, refractory, then leak; W[0][1] written on the first accept edge.
    wr(0, 40);
    for (int t = 0; t < 8; t++) begin
      timestep(spk_t[t], t == 0, 1, 40, r, rs);
      chk($sformatf("ts%0d_spikes", t), 32'(r), exp_r[t]);
      chk($sformatf("ts%0d_v0", t), 32'(dut.v_r[0]), exp_v[t]);
    end

    // Latency and backpressure: 55 - 6 + 80 = 129 fires neuron 0.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_spikes = 4'b0011;
    tick();
    in_valid = 1'b0;
    chk("bp_in_ready_low", 32'(bus.in_ready), 0);
    for (int e = 1; e < 4; e++) begin
      tick();
      chk($sformatf("bp_valid_low_e%0d", e), 32'(bus.out_valid), 0);
    end
    tick();
    chk("bp_valid_e4", 32'(bus.out_valid), 1);
    chk("bp_spikes_e4", 32'(bus.out_spikes), 1);
    w_we = 1'b1; w_addr = 4'd0; w_data = 8'd5;
    for (int c = 0; c < 5; c++) begin
      tick();
      w_we = 1'b0;
      chk("bp_hold_valid", 32'(bus.out_valid), 1);
      chk("bp_hold_spikes", 32'(bus.out_spikes), 1);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 0);
    end
    chk("done_write_ignored", 32'(dut.w_r[0]), 40);
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.out_valid), 0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 1);

    // clear_state mid-UPDATE aborts the timestep.
    in_valid  = 1'b1;
    in_spikes = 4'b0011;
    tick();
    in_valid = 1'b0;
    tick();
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    chk("clr_out_valid", 32'(bus.out_valid), 0);
    chk("clr_v0", 32'(dut.v_r[0]), 0);
    chk("clr_refrac0", 32'(dut.refrac_r[0]), 0);
    chk("clr_keeps_w1", 32'(dut.w_r[1]), 40);
    chk("clr_in_ready", 32'(bus.in_ready), 1);
    tick();
    chk("clr_out_valid_later", 32'(bus.out_valid), 0);

    // Reset mid-UPDATE after neuron 1 has fired.
    in_valid  = 1'b1;
    in_spikes = 4'b1011;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_spikes", 32'(bus.out_spikes), 2);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_spikes", 32'(bus.out_spikes), 0);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_w0", 32'(dut.w_r[0]), 0);
    chk("midrst_w7", 32'(dut.w_r[7]), 0);
    chk("midrst_v0", 32'(dut.v_r[0]), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
